// File: rtl/chip_tester_pkg.sv
// Shared types for the chip-tester controller: FSM state encoding, chip count,
// chip index type and a one-hot decode helper.
package chip_tester_pkg;

    localparam int NUM_CHIPS = 8;
    localparam int CHIP_W    = $clog2(NUM_CHIPS);

    typedef logic [CHIP_W-1:0] chip_idx_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        CONFIRM   = 3'd3,
        SHOW      = 3'd4,
        RELEASE   = 3'd5
    } ctrl_state_e;

    function automatic logic [NUM_CHIPS-1:0] chip_onehot(input chip_idx_t idx);
        chip_onehot = {{(NUM_CHIPS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for an asynchronous push-button with a registered
// one-cycle rising-edge pulse.
module button_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn,
    output logic Pulse
);

    logic       meta_r;
    logic       sync_r;
    logic       prev_r;
    logic       armed_r;
    logic       pulse_r;
    logic [1:0] fill_r;

    // Synchroniser chain; edges only count once the settled level has been seen low,
    // so a button held through reset never produces a request.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
            pulse_r <= 1'b0;
            fill_r  <= 2'b00;
        end else begin
            meta_r  <= Btn;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            fill_r  <= {fill_r[0], 1'b1};
            if (fill_r[1] && !sync_r) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
            pulse_r <= armed_r & sync_r & ~prev_r;
        end
    end

    assign Pulse = pulse_r;

endmodule

// File: rtl/test_controller.sv
// Sequencer that launches one chip tester, waits for a confirmed Done (or a
// timeout), holds the verdict for display and then releases the tester.
module test_controller
    import chip_tester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLD_CYCLES    = 25000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [2:0] Sel,
    output logic [7:0] Run_vec,
    input  logic [7:0] Done_vec,
    input  logic [7:0] RSLT_vec,
    output logic       DISP_RSLT,
    output logic       Pass,
    output logic       Fail,
    output logic       Timeout,
    output logic       Busy,
    output logic [2:0] ChipCode
);

    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    ctrl_state_e             state_r;
    ctrl_state_e             state_nxt_s;
    chip_idx_t               chip_code_r;
    chip_idx_t               chip_code_nxt_s;
    logic                    pass_r, fail_r, timeout_r;
    logic                    pass_nxt_s, fail_nxt_s, timeout_nxt_s;
    logic [TMO_W-1:0]        tmo_cnt_r, tmo_cnt_nxt_s;
    logic [HOLD_W-1:0]       hold_cnt_r, hold_cnt_nxt_s;
    logic [1:0]              rel_cnt_r, rel_cnt_nxt_s;
    logic [NUM_CHIPS-1:0]    run_vec_r, run_vec_nxt_s;
    logic                    disp_r, busy_r;
    logic                    req_s;
    logic                    done_sel_s;
    logic                    rslt_sel_s;

    button_sync u_start_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .Btn   (Start),
        .Pulse (req_s)
    );

    assign done_sel_s = Done_vec[chip_code_r];
    assign rslt_sel_s = RSLT_vec[chip_code_r];

    // Next-state and next-register values; outputs are registered from the next state
    // so Run_vec/DISP_RSLT/Busy line up exactly with the state they belong to.
    always_comb begin
        state_nxt_s     = state_r;
        chip_code_nxt_s = chip_code_r;
        pass_nxt_s      = pass_r;
        fail_nxt_s      = fail_r;
        timeout_nxt_s   = timeout_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        hold_cnt_nxt_s  = {HOLD_W{1'b0}};
        rel_cnt_nxt_s   = 2'd0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    chip_code_nxt_s = Sel;
                    pass_nxt_s      = 1'b0;
                    fail_nxt_s      = 1'b0;
                    timeout_nxt_s   = 1'b0;
                    state_nxt_s     = LAUNCH;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            LAUNCH: begin
                tmo_cnt_nxt_s = {TMO_W{1'b0}};
                state_nxt_s   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_sel_s) begin
                    state_nxt_s   = CONFIRM;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = SHOW;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1'b1);
                end
            end
            CONFIRM: begin
                // A Done that drops after one cycle is the tester's last-vector glitch.
                if (done_sel_s) begin
                    pass_nxt_s  = rslt_sel_s;
                    fail_nxt_s  = ~rslt_sel_s;
                    state_nxt_s = SHOW;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            SHOW: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s    = RELEASE;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1'b1);
                end
            end
            RELEASE: begin
                if (!done_sel_s || (rel_cnt_r == 2'd3)) begin
                    state_nxt_s   = IDLE;
                end else begin
                    rel_cnt_nxt_s = rel_cnt_r + 2'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (state_nxt_s == LAUNCH) begin
            run_vec_nxt_s = chip_onehot(chip_code_nxt_s);
        end else begin
            run_vec_nxt_s = {NUM_CHIPS{1'b0}};
        end
    end

    // State, verdict, counter and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= IDLE;
            chip_code_r <= '0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            timeout_r   <= 1'b0;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            hold_cnt_r  <= {HOLD_W{1'b0}};
            rel_cnt_r   <= 2'd0;
            run_vec_r   <= {NUM_CHIPS{1'b0}};
            disp_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            chip_code_r <= chip_code_nxt_s;
            pass_r      <= pass_nxt_s;
            fail_r      <= fail_nxt_s;
            timeout_r   <= timeout_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            rel_cnt_r   <= rel_cnt_nxt_s;
            run_vec_r   <= run_vec_nxt_s;
            disp_r      <= (state_nxt_s == RELEASE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign Run_vec   = run_vec_r;
    assign DISP_RSLT = disp_r;
    assign Pass      = pass_r;
    assign Fail      = fail_r;
    assign Timeout   = timeout_r;
    assign Busy      = busy_r;
    assign ChipCode  = chip_code_r;

endmodule

// File: tb/tb_test_controller.sv
// Directed bench for test_controller with TIMEOUT_CYCLES=16, HOLD_CYCLES=8;
// the bench plays the selected tester's Done/RSLT cycle by cycle.
module tb_test_controller;

    localparam int TMO  = 16;
    localparam int HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] sel;
    logic [7:0] run_vec;
    logic [7:0] done_vec;
    logic [7:0] rslt_vec;
    logic       disp_rslt;
    logic       pass_o, fail_o, timeout_o, busy_o;
    logic [2:0] chip_code;

    int n_cmp = 0;
    int n_err = 0;

    test_controller #(.TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .Start     (start),
        .Sel       (sel),
        .Run_vec   (run_vec),
        .Done_vec  (done_vec),
        .RSLT_vec  (rslt_vec),
        .DISP_RSLT (disp_rslt),
        .Pass      (pass_o),
        .Fail      (fail_o),
        .Timeout   (timeout_o),
        .Busy      (busy_o),
        .ChipCode  (chip_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete test: done_at=0 means the tester never finishes.
    task automatic run_case(input string nm, input logic [2:0] s, input int done_at,
                            input logic rslt, input bit glitch, input bit stuck, input bit repress);
        logic [7:0] oh;
        logic       dval;
        logic       rbit;
        bit         launched;
        bit         finished;
        bit         dropped;
        int         vfirst, dfirst, dcnt, extra_run, rep_k, busy_after;
        int         exp_v;
        oh = 8'd1 << s;
        sel = s;
        done_vec = ~oh;
        rslt_vec = rslt ? ~oh : 8'hFF;
        launched = 1'b0; finished = 1'b0; dropped = 1'b0;
        vfirst = -1; dfirst = -1; dcnt = 0; extra_run = 0; rep_k = -1; busy_after = 0;

        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (run_vec != 8'h00) begin
                launched = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_val({nm, " launched"}, {31'd0, launched}, 32'd1);
        check_val({nm, " run_vec"}, {24'd0, run_vec}, {24'd0, oh});
        check_val({nm, " chipcode@launch"}, {29'd0, chip_code}, {29'd0, s});
        check_val({nm, " busy@launch"}, {31'd0, busy_o}, 32'd1);
        check_val({nm, " verdict cleared"}, {29'd0, pass_o, fail_o, timeout_o}, 32'd0);

        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (run_vec != 8'h00) extra_run++;
            if ((pass_o | fail_o | timeout_o) && vfirst < 0) begin
                vfirst = k;
                if (repress) begin
                    sel = 3'd7;
                    start = 1'b1;
                    rep_k = k;
                end
            end
            if (rep_k > 0 && k == rep_k + 3) start = 1'b0;
            if (disp_rslt) begin
                if (dfirst < 0) dfirst = k;
                dcnt++;
                if (!stuck) dropped = 1'b1;
            end
            if (dfirst >= 0 && !disp_rslt) begin
                finished = 1'b1;
                break;
            end
            dval = (done_at != 0) && ((k >= done_at) || (glitch && k == 2)) && !dropped;
            rbit = (glitch && k < done_at) ? ~rslt : rslt;
            done_vec = dval ? 8'hFF : ~oh;
            rslt_vec = rbit ? ~oh | oh : ~oh;
            if (!rbit) rslt_vec = 8'hFF & ~oh;
            else rslt_vec = 8'h00 | oh;
        end
        start = 1'b0;
        exp_v = (done_at == 0) ? TMO + 1 : done_at + 2;
        check_val({nm, " finished"}, {31'd0, finished}, 32'd1);
        check_val({nm, " verdict cycle"}, vfirst, exp_v);
        check_val({nm, " show length"}, dfirst - vfirst, HOLD);
        check_val({nm, " disp cycles"}, dcnt, stuck ? 32'd4 : 32'd1);
        check_val({nm, " single run"}, extra_run, 32'd0);
        check_val({nm, " busy@end"}, {31'd0, busy_o}, 32'd0);
        if (done_at == 0)
            check_val({nm, " verdict"}, {29'd0, pass_o, fail_o, timeout_o}, 32'b001);
        else
            check_val({nm, " verdict"}, {29'd0, pass_o, fail_o, timeout_o}, {29'd0, rslt, ~rslt, 1'b0});
        check_val({nm, " chipcode@end"}, {29'd0, chip_code}, {29'd0, s});
        done_vec = 8'h00;
        rslt_vec = 8'h00;
        if (repress) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (busy_o) busy_after++;
            end
            check_val({nm, " repress ignored"}, busy_after, 32'd0);
            check_val({nm, " chipcode kept"}, {29'd0, chip_code}, {29'd0, s});
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int bad;
        bit got_run;
        rst_n = 1'b0; start = 1'b0; sel = 3'd0; done_vec = 8'h00; rslt_vec = 8'h00;
        repeat (3) @(negedge clk);
        check_val("reset outputs", {14'd0, run_vec, disp_rslt, pass_o, fail_o, timeout_o, busy_o, chip_code}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_case("pass3",   3'd3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_case("fail0",   3'd0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_case("tmo5",    3'd5, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_case("glitch2", 3'd2, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        run_case("repress6",3'd6, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        run_case("stuck1",  3'd1, 3, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of WAIT_DONE.
        sel = 3'd4;
        got_run = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (run_vec != 8'h00) begin
                got_run = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_val("rst test launched", {31'd0, got_run}, 32'd1);
        repeat (5) @(negedge clk);
        check_val("busy before reset", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid-test reset outputs", {14'd0, run_vec, disp_rslt, pass_o, fail_o, timeout_o, busy_o, chip_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (run_vec != 8'h00 || disp_rslt || busy_o) bad++;
        end
        check_val("quiet after reset", bad, 32'd0);

        // Start held high across reset release must not count as a press.
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy_o || run_vec != 8'h00) bad++;
        end
        check_val("held start ignored", bad, 32'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        run_case("post_rst7", 3'd7, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
